// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the staging-FIFO write-side control logic.
package fifo_ctrl_pkg;

   localparam int FIFO_DATA_W = 48;
   localparam int FIFO_DEPTH  = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin first-one finder: returns the first set bit of req found by
// scanning upward from start and wrapping modulo N.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   // Index that is off positions past start, wrapped into 0..N-1.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N) begin
         s = s - N;
      end
      return IDX_W'(s);
   endfunction

   // Scan every position once; the first hit in scan order wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[wrap_add(start, i)]) begin
            found = 1'b1;
            idx   = wrap_add(start, i);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter and credit controller for the staging FIFO.
// Producers are granted whole bursts in turn; beats are only accepted while
// the locally tracked occupancy shows a free slot, so the FIFO's lagging
// full flag is never needed.
module fifo_wr_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = FIFO_DATA_W,
   parameter int DEPTH   = FIFO_DEPTH,
   parameter int CNT_W   = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_last,
   input  logic [NUM_REQ*DATA_W-1:0]    req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic                         rd_pop,
   output logic                         fifo_wr_en,
   output logic [DATA_W-1:0]            fifo_wr_data,
   output logic                         grant_valid,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic [CNT_W-1:0]             occupancy,
   output logic                         err_pop_empty
);

   localparam int ID_W = $clog2(NUM_REQ);

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                grant_valid_q, grant_valid_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [CNT_W-1:0]    occupancy_q, occupancy_d;
   logic                wr_en_q, wr_en_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                err_q, err_d;

   logic                pick_found;
   logic [ID_W-1:0]     pick_idx;
   logic                credit_ok;
   logic                owner_valid;
   logic                owner_last;
   logic [DATA_W-1:0]   owner_data;
   logic                accept;
   logic                pop_ok;

   // Saturating occupancy update: a simultaneous push and pop cancel out,
   // and the count is clamped to 0..DEPTH.
   function automatic logic [CNT_W-1:0] occ_next(input logic [CNT_W-1:0] cur,
                                                 input logic inc,
                                                 input logic dec);
      logic [CNT_W-1:0] nxt;
      nxt = cur;
      if (inc && !dec && (cur < CNT_W'(DEPTH))) begin
         nxt = cur + 1'b1;
      end else if (dec && !inc && (cur != '0)) begin
         nxt = cur - 1'b1;
      end
      return nxt;
   endfunction

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_rr_pick (
      .req   (req_valid),
      .start (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Credit and ready use registered occupancy only; a pop this cycle
   // frees its slot for the next cycle, not this one.
   always_comb begin
      credit_ok   = (occupancy_q < CNT_W'(DEPTH));
      owner_valid = req_valid[grant_id_q];
      owner_last  = req_last[grant_id_q];
      owner_data  = req_data[int'(grant_id_q)*DATA_W +: DATA_W];
      accept      = (state_q == BURST) && owner_valid && credit_ok;
      pop_ok      = rd_pop && (occupancy_q != '0);
      req_ready   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = (state_q == BURST) && (grant_id_q == ID_W'(i)) && credit_ok;
      end
   end

   // Next-state logic for the arbiter FSM, write stage, counter and error flag.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      occupancy_d   = occ_next(occupancy_q, accept, pop_ok);
      wr_en_d       = accept;
      wr_data_d     = accept ? owner_data : wr_data_q;
      err_d         = err_q | (rd_pop && (occupancy_q == '0));

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d       = BURST;
               grant_valid_d = 1'b1;
               grant_id_d    = pick_idx;
            end
         end
         BURST: begin
            if (accept && owner_last) begin
               state_d       = IDLE;
               grant_valid_d = 1'b0;
               rr_ptr_d      = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
            end
         end
         default: begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset abandons any burst and drops a pending write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         occupancy_q   <= '0;
         wr_en_q       <= 1'b0;
         wr_data_q     <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         occupancy_q   <= occupancy_d;
         wr_en_q       <= wr_en_d;
         wr_data_q     <= wr_data_d;
         err_q         <= err_d;
      end
   end

   assign fifo_wr_en    = wr_en_q;
   assign fifo_wr_data  = wr_data_q;
   assign grant_valid   = grant_valid_q;
   assign grant_id      = grant_id_q;
   assign occupancy     = occupancy_q;
   assign err_pop_empty = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_fifo_wr_arbiter;

   localparam int NR  = 4;
   localparam int DW  = 48;
   localparam int DEP = 4;
   localparam int CW  = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    rv;
   logic [NR-1:0]    rl;
   logic [NR*DW-1:0] rdat;
   logic [NR-1:0]    rdy;
   logic             pop;
   logic             wr_en;
   logic [DW-1:0]    wr_data;
   logic             gv;
   logic [1:0]       gid;
   logic [CW-1:0]    occ;
   logic             err;

   int total = 0;
   int bad   = 0;

   // reference model: owner index (-1 when none), next search start, word count
   int          m_owner;
   int          m_ptr;
   int          m_occ;
   int          m_gid;
   logic        m_wr_en;
   logic [DW-1:0] m_wr_data;
   logic        m_err;

   fifo_wr_arbiter #(
      .NUM_REQ (NR),
      .DATA_W  (DW),
      .DEPTH   (DEP),
      .CNT_W   (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (rv),
      .req_last      (rl),
      .req_data      (rdat),
      .req_ready     (rdy),
      .rd_pop        (pop),
      .fifo_wr_en    (wr_en),
      .fifo_wr_data  (wr_data),
      .grant_valid   (gv),
      .grant_id      (gid),
      .occupancy     (occ),
      .err_pop_empty (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      m_owner   = -1;
      m_ptr     = 0;
      m_occ     = 0;
      m_gid     = 0;
      m_wr_en   = 1'b0;
      m_wr_data = '0;
      m_err     = 1'b0;
   endtask

   function automatic logic [NR-1:0] m_ready();
      logic [NR-1:0] r;
      r = '0;
      if (m_owner >= 0 && m_occ < DEP) r[m_owner] = 1'b1;
      return r;
   endfunction

   // One clock of the abstract model, using the inputs present at the edge.
   task automatic model_clock();
      int acc;
      int popped;
      acc    = (m_owner >= 0 && rv[m_owner] && m_occ < DEP) ? 1 : 0;
      popped = (pop && m_occ > 0) ? 1 : 0;
      if (pop && m_occ == 0) m_err = 1'b1;
      m_wr_en = (acc == 1);
      if (acc == 1) m_wr_data = rdat[m_owner*DW +: DW];
      m_occ = m_occ + acc - popped;
      if (m_owner < 0) begin
         for (int k = 0; k < NR; k++) begin
            if (m_owner < 0 && rv[(m_ptr + k) % NR]) begin
               m_owner = (m_ptr + k) % NR;
               m_gid   = m_owner;
            end
         end
      end else if (acc == 1 && rl[m_owner]) begin
         m_ptr   = (m_owner + 1) % NR;
         m_owner = -1;
      end
   endtask

   task automatic check_regs();
      check("grant_valid", gv, (m_owner >= 0));
      check("grant_id", gid, m_gid);
      check("occupancy", occ, m_occ);
      check("fifo_wr_en", wr_en, m_wr_en);
      check("fifo_wr_data", wr_data, m_wr_data);
      check("err_pop_empty", err, m_err);
   endtask

   task automatic tick();
      @(negedge clk);
      check("req_ready", rdy, m_ready());
      @(posedge clk);
      model_clock();
      #1;
      check_regs();
   endtask

   task automatic apply_reset();
      rv    = '0;
      rl    = '0;
      pop   = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      check_regs();
      check("reset_ready", rdy, '0);
   endtask

   task automatic rand_data();
      for (int w = 0; w < NR; w++) begin
         rdat[w*DW +: DW] = {$urandom, $urandom};
      end
   endtask

   initial begin
      int          order[$];
      logic        prev_gv;
      logic [DW-1:0] beat5;
      int          guard;

      reset = 1'b1;
      rv    = '0;
      rl    = '0;
      pop   = 1'b0;
      rdat  = '0;
      model_reset();

      // single-beat burst from requester 0
      apply_reset();
      rv = 4'b0001;
      rl = 4'b0001;
      rdat[0 +: DW] = 48'hA5A5_0000_0001;
      tick();
      check("t1_grant", gv, 1'b1);
      tick();
      check("t1_wr_en", wr_en, 1'b1);
      check("t1_wr_data", wr_data, 48'hA5A5_0000_0001);
      check("t1_occ", occ, 1);
      rv = '0;
      tick();
      tick();

      // all requesters valid, single beats, pop every cycle
      apply_reset();
      rv = 4'b1111;
      rl = 4'b1111;
      pop = 1'b1;
      prev_gv = 1'b0;
      for (int c = 0; c < 24; c++) begin
         rand_data();
         tick();
         if (gv && !prev_gv) order.push_back(int'(gid));
         prev_gv = gv;
         check("t2_occ_le1", (occ <= 1), 1'b1);
      end
      check("t2_grant_count", (order.size() >= 5), 1'b1);
      for (int i = 0; i < 5; i++) begin
         if (i < order.size()) check("t2_order", order[i], i % 4);
      end

      // requester 2 long burst fills the FIFO, then one pop frees a slot
      apply_reset();
      rv = 4'b0100;
      rl = 4'b0000;
      for (int c = 0; c < 6; c++) begin
         rand_data();
         tick();
      end
      check("t3_occ_full", occ, 4);
      check("t3_ready_full", rdy, 4'b0000);
      rand_data();
      pop = 1'b1;
      tick();
      pop = 1'b0;
      check("t4_occ_after_pop", occ, 3);
      check("t4_no_accept", wr_en, 1'b0);
      rand_data();
      beat5 = rdat[2*DW +: DW];
      tick();
      check("t4_accept_next", wr_en, 1'b1);
      check("t4_beat5_data", wr_data, beat5);
      check("t4_occ_refull", occ, 4);
      pop = 1'b1;
      rl = 4'b0100;
      guard = 0;
      while (gv && guard < 20) begin
         rand_data();
         tick();
         guard++;
      end
      check("t3_burst_ends", gv, 1'b0);
      rv = '0;
      rl = '0;
      pop = 1'b0;

      // pop while empty sets the sticky error
      apply_reset();
      pop = 1'b1;
      tick();
      pop = 1'b0;
      check("t5_occ_zero", occ, 0);
      check("t5_err_set", err, 1'b1);
      tick();
      tick();
      check("t5_err_sticky", err, 1'b1);
      apply_reset();
      check("t5_err_cleared", err, 1'b0);

      // reset during a burst with a write pending
      rv = 4'b0010;
      rl = 4'b0000;
      rdat[1*DW +: DW] = 48'h1234_5678_9ABC;
      tick();
      tick();
      check("t6_pending", wr_en, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_gv", gv, 1'b0);
      check("t6_gid", gid, 0);
      check("t6_occ", occ, 0);
      check("t6_wr_en", wr_en, 1'b0);
      check("t6_wr_data", wr_data, 0);
      check("t6_err", err, 1'b0);
      check("t6_ready", rdy, 4'b0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      rv = 4'b1111;
      rl = 4'b1111;
      tick();
      check("t6_restart_gv", gv, 1'b1);
      check("t6_restart_id", gid, 0);

      // random traffic
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         rv = 4'($urandom);
         for (int b = 0; b < NR; b++) rl[b] = ($urandom_range(0, 2) == 0);
         pop = ($urandom_range(0, 2) == 0);
         rand_data();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
